// File: rtl/ib_mul_arb.sv
// ----------------------------------------------------------------------------
// ib_mul_arb
//   Round-robin arbiter/sequencer sharing one external 8x8 unsigned multiplier
//   between four requesters. A granted operand pair is latched and held on
//   o_mul_a/o_mul_b for LAT+1 cycles. The product is then captured and
//   returned to the same requester over a valid/ready response handshake.
//
// Parameters
//   LAT        multiplier latency in cycles (0 = combinational), 0..15
//
// Ports
//   i_clk      clock, rising edge
//   i_nrst     asynchronous active-low reset
//   i_req_vld  [3:0]  per-requester operand valid
//   o_req_rdy  [3:0]  per-requester accept (one-hot or zero, combinational)
//   i_req_a    [31:0] operand A, requester n in bits [8n+7:8n]
//   i_req_b    [31:0] operand B, requester n in bits [8n+7:8n]
//   o_rsp_vld  [3:0]  per-requester result valid (one-hot or zero)
//   i_rsp_rdy  [3:0]  per-requester result accept
//   o_rsp_c    [15:0] product for the requester flagged in o_rsp_vld
//   o_mul_a    [7:0]  operand A to the multiplier
//   o_mul_b    [7:0]  operand B to the multiplier
//   i_mul_c    [15:0] product from the multiplier
//   o_busy     high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module ib_mul_arb #(
   parameter int unsigned LAT = 0
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic [3:0]  i_req_vld,
   output logic [3:0]  o_req_rdy,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   output logic [3:0]  o_rsp_vld,
   input  logic [3:0]  i_rsp_rdy,
   output logic [15:0] o_rsp_c,
   output logic [7:0]  o_mul_a,
   output logic [7:0]  o_mul_b,
   input  logic [15:0] i_mul_c,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  op_a_q, op_a_d;
   logic [7:0]  op_b_q, op_b_d;
   logic [15:0] res_q, res_d;

   // Round-robin search: scan offsets from the highest down so that the
   // requester closest to ptr_q (smallest offset) is the one left selected.
   logic [1:0] sel;
   logic       found;

   always_comb begin
      found = 1'b0;
      sel   = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         if (i_req_vld[ptr_q + 2'(i)]) begin
            found = 1'b1;
            sel   = ptr_q + 2'(i);
         end
      end
   end

   // Next-state and decoded outputs.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      res_d     = res_q;
      o_req_rdy = 4'b0000;

      case (state_q)
         IDLE: begin
            if (found) begin
               o_req_rdy = 4'b0001 << sel;
               op_a_d    = i_req_a[8*sel +: 8];
               op_b_d    = i_req_b[8*sel +: 8];
               gnt_d     = sel;
               cnt_d     = 4'(LAT);
               ptr_d     = sel + 2'd1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               res_d   = i_mul_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            // Only the granted requester's ready bit can retire the response.
            if (i_rsp_rdy[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register, independent of
   // statement order.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gnt_q   <= 2'd0;
         cnt_q   <= 4'd0;
         op_a_q  <= 8'd0;
         op_b_q  <= 8'd0;
         res_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
      end
   end

   // Operand and result registers drive the outputs directly, so they hold
   // their last values outside the states that update them.
   assign o_mul_a   = op_a_q;
   assign o_mul_b   = op_b_q;
   assign o_rsp_c   = res_q;
   assign o_rsp_vld = (state_q == DONE) ? (4'b0001 << gnt_q) : 4'b0000;
   assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ib_mul_arb.sv
// ----------------------------------------------------------------------------
// tb_ib_mul_arb
//   Self-checking bench for ib_mul_arb. Two instances share the request-side
//   stimulus: u_dut0 (LAT=0) with a combinational multiplier and u_dut3
//   (LAT=3) with a 3-stage pipelined multiplier model. Each test resets both
//   and checks only the instance it targets.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ib_mul_arb;

   logic        clk;
   logic        nrst;
   logic [3:0]  req_vld;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  rsp_rdy;

   logic [3:0]  rdy0, vld0, rdy3, vld3;
   logic [15:0] c0, c3, mul_c0, mul_c3;
   logic [7:0]  mul_a0, mul_b0, mul_a3, mul_b3;
   logic        busy0, busy3;

   int n_vec = 0;
   int n_err = 0;

   ib_mul_arb #(.LAT(0)) u_dut0 (
      .i_clk(clk), .i_nrst(nrst),
      .i_req_vld(req_vld), .o_req_rdy(rdy0),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_rsp_vld(vld0), .i_rsp_rdy(rsp_rdy), .o_rsp_c(c0),
      .o_mul_a(mul_a0), .o_mul_b(mul_b0), .i_mul_c(mul_c0),
      .o_busy(busy0)
   );

   ib_mul_arb #(.LAT(3)) u_dut3 (
      .i_clk(clk), .i_nrst(nrst),
      .i_req_vld(req_vld), .o_req_rdy(rdy3),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_rsp_vld(vld3), .i_rsp_rdy(rsp_rdy), .o_rsp_c(c3),
      .o_mul_a(mul_a3), .o_mul_b(mul_b3), .i_mul_c(mul_c3),
      .o_busy(busy3)
   );

   // Multiplier models.
   assign mul_c0 = 16'(mul_a0) * 16'(mul_b0);

   logic [15:0] p1, p2, p3;
   always @(posedge clk) begin
      p1 <= 16'(mul_a3) * 16'(mul_b3);
      p2 <= p1;
      p3 <= p2;
   end
   assign mul_c3 = p3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          port;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] c;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst    = 1'b0;
      req_vld = 4'b0000;
      req_a   = '0;
      req_b   = '0;
      rsp_rdy = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   // One full LAT=0 transaction on u_dut0 starting in an IDLE cycle T.
   // Returns in cycle T+3, which is IDLE again.
   task automatic do_op(input int port, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_c);
      req_a = $urandom;
      req_b = $urandom;
      req_a[8*port +: 8] = a;
      req_b[8*port +: 8] = b;
      req_vld = 4'b0001 << port;
      rsp_rdy = 4'hF;
      #1;
      check("op_req_rdy_T", 32'(rdy0), 32'(4'b0001 << port));
      check("op_busy_T", 32'(busy0), 32'd0);
      cyc();
      // Operands must no longer matter once accepted.
      req_vld = 4'b0000;
      req_a   = $urandom;
      req_b   = $urandom;
      #1;
      check("op_busy_T1", 32'(busy0), 32'd1);
      check("op_req_rdy_T1", 32'(rdy0), 32'd0);
      check("op_rsp_vld_T1", 32'(vld0), 32'd0);
      cyc();
      check("op_rsp_vld_T2", 32'(vld0), 32'(4'b0001 << port));
      check("op_rsp_c_T2", 32'(c0), 32'(exp_c));
      cyc();
      check("op_busy_T3", 32'(busy0), 32'd0);
   endtask

   initial begin
      tbl[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
      tbl[1] = '{0, 8'h12, 8'h34, 16'h03A8};
      tbl[2] = '{1, 8'h00, 8'hFF, 16'h0000};
      tbl[3] = '{3, 8'h01, 8'hFF, 16'h00FF};
      tbl[4] = '{1, 8'h80, 8'h02, 16'h0100};
      tbl[5] = '{0, 8'h0F, 8'h0F, 16'h00E1};
      tbl[6] = '{3, 8'h10, 8'h10, 16'h0100};
      tbl[7] = '{2, 8'hAA, 8'h55, 16'h3872};
      tbl[8] = '{1, 8'hFF, 8'h01, 16'h00FF};
      tbl[9] = '{0, 8'h07, 8'h09, 16'h003F};

      // ---------------- reset state ----------------
      do_reset();
      #1;
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_req_rdy", 32'(rdy0), 32'd0);
      check("rst_rsp_vld", 32'(vld0), 32'd0);
      check("rst_rsp_c", 32'(c0), 32'd0);
      check("rst_mul_a", 32'(mul_a0), 32'd0);
      check("rst_mul_b", 32'(mul_b0), 32'd0);
      check("rst_busy3", 32'(busy3), 32'd0);

      // ---------------- directed vector table (LAT=0) ----------------
      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].c);
      end

      // ---------------- fairness: all four requesting ----------------
      do_reset();
      for (int n = 0; n < 4; n++) begin
         req_a[8*n +: 8] = 8'(n + 1);
         req_b[8*n +: 8] = 8'h10;
      end
      req_vld = 4'hF;
      rsp_rdy = 4'hF;
      for (int k = 0; k < 15; k++) begin
         int g;
         g = (k / 3) % 4;
         #1;
         case (k % 3)
            0: begin
               check("fair_grant", 32'(rdy0), 32'(4'b0001 << g));
               check("fair_idle", 32'(busy0), 32'd0);
            end
            1: begin
               check("fair_busy", 32'(busy0), 32'd1);
               check("fair_no_grant", 32'(rdy0), 32'd0);
            end
            default: begin
               check("fair_rsp_vld", 32'(vld0), 32'(4'b0001 << g));
               check("fair_rsp_c", 32'(c0), 32'h10 * 32'(g + 1));
            end
         endcase
         @(posedge clk);
      end

      // ---------------- back-pressure ----------------
      do_reset();
      req_a = $urandom;
      req_b = $urandom;
      req_a[7:0] = 8'h12;
      req_b[7:0] = 8'h34;
      req_vld = 4'hF;
      rsp_rdy = 4'b0000;
      #1;
      check("bp_grant", 32'(rdy0), 32'h1);
      cyc();
      check("bp_busy", 32'(busy0), 32'd1);
      cyc();
      rsp_rdy = 4'b1110;  // other requesters' ready bits must be ignored
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_hold_vld", 32'(vld0), 32'h1);
         check("bp_hold_c", 32'(c0), 32'h03A8);
         check("bp_no_grant", 32'(rdy0), 32'd0);
         cyc();
      end
      rsp_rdy = 4'hF;
      #1;
      check("bp_release_vld", 32'(vld0), 32'h1);
      cyc();
      check("bp_idle", 32'(busy0), 32'd0);
      check("bp_idle_vld", 32'(vld0), 32'd0);
      check("bp_next_grant", 32'(rdy0), 32'h2);

      // ---------------- LAT=3 pipelined multiplier ----------------
      do_reset();
      req_a = $urandom;
      req_b = $urandom;
      req_a[7:0] = 8'h80;
      req_b[7:0] = 8'h02;
      req_vld = 4'b0001;
      rsp_rdy = 4'hF;
      #1;
      check("l3_grant", 32'(rdy3), 32'h1);
      cyc();
      req_vld = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         req_a = $urandom;
         req_b = $urandom;
         #1;
         check("l3_busy", 32'(busy3), 32'd1);
         check("l3_mul_a", 32'(mul_a3), 32'h80);
         check("l3_mul_b", 32'(mul_b3), 32'h02);
         check("l3_no_vld", 32'(vld3), 32'd0);
         cyc();
      end
      check("l3_rsp_vld", 32'(vld3), 32'h1);
      check("l3_rsp_c", 32'(c3), 32'h0100);
      cyc();
      check("l3_idle", 32'(busy3), 32'd0);

      // ---------------- reset mid-operation (LAT=3) ----------------
      do_reset();
      req_a[31:24] = 8'h05;
      req_b[31:24] = 8'h06;
      req_vld = 4'b1000;
      rsp_rdy = 4'hF;
      #1;
      check("mr_grant", 32'(rdy3), 32'h8);
      cyc();
      req_vld = 4'b0000;
      #1;
      check("mr_busy1", 32'(busy3), 32'd1);
      cyc();
      nrst = 1'b0;
      #1;
      check("mr_rst_req_rdy", 32'(rdy3), 32'd0);
      check("mr_rst_rsp_vld", 32'(vld3), 32'd0);
      check("mr_rst_rsp_c", 32'(c3), 32'd0);
      check("mr_rst_mul_a", 32'(mul_a3), 32'd0);
      check("mr_rst_mul_b", 32'(mul_b3), 32'd0);
      check("mr_rst_busy", 32'(busy3), 32'd0);
      cyc();
      cyc();
      nrst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("mr_no_rsp", 32'(vld3), 32'd0);
         check("mr_idle", 32'(busy3), 32'd0);
         cyc();
      end
      req_vld = 4'hF;
      #1;
      check("mr_ptr_reset", 32'(rdy3), 32'h1);

      // ---------------- product sweep on port 1 (LAT=0) ----------------
      do_reset();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] bv [4];
         bv[0] = 8'h00; bv[1] = 8'h01; bv[2] = 8'h7F; bv[3] = 8'hFF;
         for (int j = 0; j < 4; j++) begin
            do_op(1, 8'(a), bv[j], 16'(a) * 16'(bv[j]));
         end
      end
      for (int i = 0; i < 200; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         do_op(int'($urandom_range(3, 0)), ra, rb, 16'(ra) * 16'(rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
